// File: rtl/scroll_tile_layer_if.sv
// Tile-row ROM port of the scrolling tile layer.
// rom_req is held with a stable rom_addr until the one-cycle rom_ack that carries rom_data; the requester may withdraw rom_req early, and any ack that arrives later is ignored.
interface scroll_tile_layer_if;
    logic        rom_req;
    logic [12:0] rom_addr;
    logic [31:0] rom_data;
    logic        rom_ack;

    modport master (output rom_req, rom_addr, input rom_data, rom_ack);
    modport slave  (input rom_req, rom_addr, output rom_data, rom_ack);
endinterface

// File: rtl/scroll_tile_layer.sv
// Scrolling 8x8 tile background layer: CPU-written tile map, per-line scroll latch,
// one-tile-ahead ROM fetch and a 4bpp shifter that emits {palette, colour} per pixel.
module scroll_tile_layer #(
    parameter int MAP_COLS_LOG2 = 6,
    parameter int MAP_ROWS_LOG2 = 6,
    parameter int MAP_AW        = MAP_COLS_LOG2 + MAP_ROWS_LOG2
) (
    input  logic               clk,
    input  logic               RESET,
    input  logic               pxl_cen,
    input  logic [8:0]         hcount,
    input  logic [8:0]         vcount,
    input  logic [8:0]         scroll_x,
    input  logic [8:0]         scroll_y,
    input  logic               cpu_cs,
    input  logic               cpu_we,
    input  logic [MAP_AW:0]    cpu_addr,
    input  logic [7:0]         cpu_din,
    output logic [7:0]         cpu_dout,
    scroll_tile_layer_if.master rom,
    output logic [7:0]         pix_out,
    output logic               pix_opaque,
    output logic               underrun,
    output logic [2:0]         dbg_state
);

    localparam int WX_W = MAP_COLS_LOG2 + 3;
    localparam int WY_W = MAP_ROWS_LOG2 + 3;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_MAP_RD  = 3'd1;
    localparam logic [2:0] S_MAP_LAT = 3'd2;
    localparam logic [2:0] S_ROM_REQ = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [7:0] vram_lo [2**MAP_AW];
    logic [7:0] vram_hi [2**MAP_AW];

    logic [2:0]        state;
    logic [8:0]        sx, sy;
    logic [8:0]        sx_cur, sy_cur;
    logic [WX_W-1:0]   wxa;
    logic [WY_W-1:0]   wy;
    logic              trigger;
    logic [MAP_AW-1:0] vid_addr;
    logic [7:0]        vid_lo, vid_hi;
    logic [2:0]        fetch_row;
    logic [3:0]        fetch_pal;
    logic              fetch_flipx;
    logic [31:0]       pending;
    logic [3:0]        pend_pal;
    logic [31:0]       shifter;
    logic [3:0]        cur_pal;
    logic [31:0]       load_word;
    logic [3:0]        load_pal;
    logic [3:0]        out_nib;
    logic [3:0]        out_pal;
    logic [31:0]       next_shift;
    logic [31:0]       rom_rev;

    assign dbg_state = state;

    // The first pixel of a line already uses the scroll value being latched on it.
    assign sx_cur  = (hcount == 9'd0) ? scroll_x : sx;
    assign sy_cur  = (hcount == 9'd0) ? scroll_y : sy;
    assign wxa     = WX_W'({1'b0, hcount} + {1'b0, sx_cur} + 10'd8);
    assign wy      = WY_W'({1'b0, vcount} + {1'b0, sy_cur});
    assign trigger = pxl_cen && (wxa[2:0] == 3'd0);

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            rom_rev[4*i +: 4] = rom.rom_data[28-4*i +: 4];
        end
    end

    // CPU port: write-first is not wanted, a same-address read sees the old byte.
    always_ff @(posedge clk) begin
        if (cpu_cs && cpu_we) begin
            if (cpu_addr[0]) vram_hi[cpu_addr[MAP_AW:1]] <= cpu_din;
            else             vram_lo[cpu_addr[MAP_AW:1]] <= cpu_din;
        end
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            cpu_dout <= 8'd0;
        end else if (cpu_cs) begin
            cpu_dout <= cpu_addr[0] ? vram_hi[cpu_addr[MAP_AW:1]] : vram_lo[cpu_addr[MAP_AW:1]];
        end
    end

    always_ff @(posedge clk) begin
        vid_lo <= vram_lo[vid_addr];
        vid_hi <= vram_hi[vid_addr];
    end

    always_comb begin
        load_word  = (state == S_DONE) ? pending : 32'd0;
        load_pal   = (state == S_DONE) ? pend_pal : 4'd0;
        out_nib    = shifter[31:28];
        out_pal    = cur_pal;
        next_shift = {shifter[27:0], 4'h0};
        if (trigger) begin
            out_nib    = load_word[31:28];
            out_pal    = load_pal;
            next_shift = {load_word[27:0], 4'h0};
        end
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state        <= S_IDLE;
            sx           <= 9'd0;
            sy           <= 9'd0;
            vid_addr     <= '0;
            fetch_row    <= 3'd0;
            fetch_pal    <= 4'd0;
            fetch_flipx  <= 1'b0;
            rom.rom_req  <= 1'b0;
            rom.rom_addr <= 13'd0;
            pending      <= 32'd0;
            pend_pal     <= 4'd0;
            shifter      <= 32'd0;
            cur_pal      <= 4'd0;
            pix_out      <= 8'd0;
            pix_opaque   <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            if (pxl_cen && hcount == 9'd0) begin
                sx <= scroll_x;
                sy <= scroll_y;
            end

            // A trigger always starts the next fetch; arriving before DONE means the
            // previous tile never made it and is shown transparent.
            if (trigger) begin
                vid_addr    <= {wy[WY_W-1:3], wxa[WX_W-1:3]};
                fetch_row   <= wy[2:0];
                rom.rom_req <= 1'b0;
                state       <= S_MAP_RD;
                if (state != S_DONE && state != S_IDLE) underrun <= 1'b1;
            end else begin
                case (state)
                    S_MAP_RD: state <= S_MAP_LAT;
                    S_MAP_LAT: begin
                        rom.rom_addr <= {vid_hi[1:0], vid_lo, fetch_row ^ {3{vid_hi[7]}}};
                        fetch_pal    <= vid_hi[5:2];
                        fetch_flipx  <= vid_hi[6];
                        rom.rom_req  <= 1'b1;
                        state        <= S_ROM_REQ;
                    end
                    S_ROM_REQ: begin
                        if (rom.rom_ack) begin
                            pending     <= fetch_flipx ? rom_rev : rom.rom_data;
                            pend_pal    <= fetch_pal;
                            rom.rom_req <= 1'b0;
                            state       <= S_DONE;
                        end
                    end
                    default: ;
                endcase
            end

            if (pxl_cen) begin
                pix_out    <= {out_pal, out_nib};
                pix_opaque <= (out_nib != 4'd0);
                shifter    <= next_shift;
                if (trigger) cur_pal <= load_pal;
            end
        end
    end

endmodule
